// File: rtl/param_memory.sv
// param_memory: parametrised single-port synchronous memory with byte-enabled
// writes, a configurable read pipeline, a bulk-clear sequencer and range checks.
module param_memory #(
  parameter int DATA_W = 32,               // multiple of 8
  parameter int DEPTH  = 16,               // at least 2, need not be a power of two
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1                 // 1 to 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                EN,
  input  logic                WE,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   Data_in,
  input  logic [DATA_W/8-1:0] BE,
  input  logic                CLR,
  output logic [DATA_W-1:0]   Data_out,
  output logic                Valid_out,
  output logic                Err,
  output logic                Busy,
  output logic [0:0]          fsm_state
);

  // Handshake: a request is accepted on any rising edge where EN=1, CLR=0 and
  // the FSM is IDLE; there is no backpressure. Each accepted read yields exactly
  // one Valid_out pulse RD_LAT cycles later; Data_out is meaningful only while
  // Valid_out=1 and otherwise holds its previous value. Err only rides on Valid_out.

  localparam int                NBYTES    = DATA_W / 8;
  localparam logic [0:0]        IDLE      = 1'b0;
  localparam logic [0:0]        CLEAR     = 1'b1;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_addr;

  logic              in_range;
  logic              accept;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] pipe_data [RD_LAT];
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_err;

  always_comb begin
    in_range = ({1'b0, address} < DEPTH_X);
    accept   = (state == IDLE) && !CLR && EN;
    wr_acc   = accept && WE;
    rd_acc   = accept && !WE;
    rd_word  = '0;
    if (in_range) rd_word = mem[address];
  end

  // Array has no reset; the clear sequencer is the only way to zero it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc && in_range) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (BE[i]) mem[address][8*i +: 8] <= Data_in[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      clr_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (CLR) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end
        end
        CLEAR: begin
          if (clr_addr == LAST_ADDR) state <= IDLE;
          else                       clr_addr <= clr_addr + 1'b1;
        end
      endcase
    end
  end

  // Data stages only load behind a valid token, so the last stage holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld <= '0;
      pipe_err <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_data[i] <= '0;
    end else begin
      pipe_vld[0] <= rd_acc;
      pipe_err[0] <= rd_acc && !in_range;
      if (rd_acc) pipe_data[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_err[i] <= pipe_err[i-1];
        if (pipe_vld[i-1]) pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign Data_out  = pipe_data[RD_LAT-1];
  assign Valid_out = pipe_vld[RD_LAT-1];
  assign Err       = pipe_err[RD_LAT-1];
  assign Busy      = (state == CLEAR);
  assign fsm_state = state;

endmodule

// File: tb/tb_param_memory.sv
// tb_param_memory: three param_memory configurations (16x32/lat1, 16x32/lat3,
// 12x32/lat2) driven by directed vectors and checked through one scoreboard queue.
module tb_param_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en_s   [3];
  logic        we_s   [3];
  logic        clr_s  [3];
  logic [3:0]  addr_s [3];
  logic [31:0] din_s  [3];
  logic [3:0]  be_s   [3];
  logic [31:0] dout_s [3];
  logic        vld_s  [3];
  logic        err_s  [3];
  logic        busy_s [3];
  logic [0:0]  st_s   [3];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  // entry: [66:65] instance, [64:33] due cycle, [32] err, [31:0] data
  logic [66:0] exp_q[$];

  param_memory #(.DATA_W(32), .DEPTH(16), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst), .EN(en_s[0]), .WE(we_s[0]), .address(addr_s[0]),
    .Data_in(din_s[0]), .BE(be_s[0]), .CLR(clr_s[0]), .Data_out(dout_s[0]),
    .Valid_out(vld_s[0]), .Err(err_s[0]), .Busy(busy_s[0]), .fsm_state(st_s[0]));

  param_memory #(.DATA_W(32), .DEPTH(16), .RD_LAT(3)) u_b (
    .clk(clk), .rst(rst), .EN(en_s[1]), .WE(we_s[1]), .address(addr_s[1]),
    .Data_in(din_s[1]), .BE(be_s[1]), .CLR(clr_s[1]), .Data_out(dout_s[1]),
    .Valid_out(vld_s[1]), .Err(err_s[1]), .Busy(busy_s[1]), .fsm_state(st_s[1]));

  param_memory #(.DATA_W(32), .DEPTH(12), .RD_LAT(2)) u_c (
    .clk(clk), .rst(rst), .EN(en_s[2]), .WE(we_s[2]), .address(addr_s[2]),
    .Data_in(din_s[2]), .BE(be_s[2]), .CLR(clr_s[2]), .Data_out(dout_s[2]),
    .Valid_out(vld_s[2]), .Err(err_s[2]), .Busy(busy_s[2]), .fsm_state(st_s[2]));

  always @(posedge clk) cyc++;

  function automatic int lat(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 2);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      en_s[i] = 1'b0; we_s[i] = 1'b0; clr_s[i] = 1'b0;
      addr_s[i] = '0; din_s[i] = '0; be_s[i] = '0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      idle_all();
    end
  endtask

  task automatic wr(input int i, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    idle_all();
    en_s[i] = 1'b1; we_s[i] = 1'b1; addr_s[i] = a; din_s[i] = d; be_s[i] = be;
  endtask

  task automatic rd(input int i, input logic [3:0] a, input logic [31:0] d, input logic e);
    @(negedge clk);
    idle_all();
    en_s[i] = 1'b1; addr_s[i] = a;
    exp_q.push_back({i[1:0], 32'(cyc + lat(i)), e, d});
  endtask

  task automatic check_inst(input int i);
    int          idx;
    logic [66:0] e;
    idx = -1;
    for (int j = 0; j < exp_q.size(); j++)
      if (idx < 0 && exp_q[j][66:65] == i[1:0]) idx = j;
    if (err_s[i] === 1'b1 && vld_s[i] !== 1'b1) begin
      total++; bad++;
      $display("FAIL err_without_valid inst=%0d got=1 exp=0", i);
    end
    if (vld_s[i] === 1'b1) begin
      if (idx < 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid inst=%0d got data=%h exp=no pulse", i, dout_s[i]);
      end else begin
        e = exp_q[idx];
        exp_q.delete(idx);
        check($sformatf("latency inst=%0d", i), 32'(cyc), e[64:33]);
        check($sformatf("data inst=%0d", i), dout_s[i], e[31:0]);
        check($sformatf("err inst=%0d", i), {31'b0, err_s[i]}, {31'b0, e[32]});
      end
    end else if (idx >= 0 && int'(exp_q[idx][64:33]) <= cyc) begin
      total++; bad++;
      $display("FAIL missing_valid inst=%0d got=0 exp=1 data=%h", i, exp_q[idx][31:0]);
      exp_q.delete(idx);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) check_inst(i);
  end

  initial begin
    int  busy_cnt [3];
    logic done;

    rst = 1'b1;
    idle_all();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_dout inst=%0d", i), dout_s[i], 32'h0);
      check($sformatf("reset_valid inst=%0d", i), {31'b0, vld_s[i]}, 32'h0);
      check($sformatf("reset_err inst=%0d", i), {31'b0, err_s[i]}, 32'h0);
      check($sformatf("reset_busy inst=%0d", i), {31'b0, busy_s[i]}, 32'h0);
    end
    rst = 1'b1;

    // Clear all three; instance a also issues a read in the CLR cycle (dropped)
    // and keeps writing address 1 while busy (ignored).
    @(negedge clk);
    idle_all();
    for (int i = 0; i < 3; i++) clr_s[i] = 1'b1;
    en_s[0] = 1'b1; addr_s[0] = 4'd3;
    for (int i = 0; i < 3; i++) busy_cnt[i] = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      idle_all();
      done = 1'b1;
      for (int i = 0; i < 3; i++)
        if (busy_s[i]) begin busy_cnt[i]++; done = 1'b0; end
      if (busy_s[0]) begin
        en_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 4'd1;
        din_s[0] = 32'h12345678; be_s[0] = 4'hf;
      end
    end
    check("busy_cycles inst=0", 32'(busy_cnt[0]), 32'd16);
    check("busy_cycles inst=1", 32'(busy_cnt[1]), 32'd16);
    check("busy_cycles inst=2", 32'(busy_cnt[2]), 32'd12);
    check("state_idle_after_clear", {31'b0, st_s[0]}, 32'h0);

    for (int k = 0; k < 16; k++) rd(0, 4'(k), 32'h0, 1'b0);
    for (int k = 0; k < 16; k++) rd(1, 4'(k), 32'h0, 1'b0);
    for (int k = 0; k < 12; k++) rd(2, 4'(k), 32'h0, 1'b0);

    // Full write/readback at latency 1 and 3.
    for (int k = 0; k < 16; k++) wr(0, 4'(k), 32'hA5A50000 + k, 4'hf);
    for (int k = 0; k < 16; k++) rd(0, 4'(k), 32'hA5A50000 + k, 1'b0);
    for (int k = 0; k < 16; k++) wr(1, 4'(k), 32'hA5A50000 + k, 4'hf);
    for (int k = 0; k < 16; k++) rd(1, 4'(k), 32'hA5A50000 + k, 1'b0);

    // Byte enables, write immediately followed by a read of the same word.
    wr(0, 4'd5, 32'h11223344, 4'hf);
    wr(0, 4'd5, 32'hFFFFFFFF, 4'b0101);
    rd(0, 4'd5, 32'h11FF33FF, 1'b0);
    wr(0, 4'd6, 32'h00000000, 4'b1010);
    rd(0, 4'd6, 32'h00A50006, 1'b0);
    rd(0, 4'd5, 32'h11FF33FF, 1'b0);
    idle(3);
    check("dout_hold inst=0", dout_s[0], 32'h11FF33FF);

    // Out of range on the 12-deep instance.
    wr(2, 4'd11, 32'hCAFE0011, 4'hf);
    wr(2, 4'd13, 32'hDEADBEEF, 4'hf);
    rd(2, 4'd13, 32'h0, 1'b1);
    rd(2, 4'd11, 32'hCAFE0011, 1'b0);
    rd(2, 4'd12, 32'h0, 1'b1);
    rd(2, 4'd0, 32'h0, 1'b0);
    idle(4);

    // Read accepted the edge before CLR still returns pre-clear data.
    rd(1, 4'd2, 32'hA5A50002, 1'b0);
    @(negedge clk);
    idle_all();
    clr_s[1] = 1'b1;
    idle(17);
    check("busy_done inst=1", {31'b0, busy_s[1]}, 32'h0);
    rd(1, 4'd2, 32'h0, 1'b0);
    rd(1, 4'd15, 32'h0, 1'b0);
    idle(5);

    // Reset in the middle of a clear on instance a.
    for (int k = 0; k < 16; k++) wr(0, 4'(k), 32'hFFFFFFFF, 4'hf);
    rd(0, 4'd9, 32'hFFFFFFFF, 1'b0);
    idle(3);
    @(negedge clk);
    idle_all();
    clr_s[0] = 1'b1;
    idle(4);
    @(negedge clk);
    idle_all();
    check("busy_mid_clear inst=0", {31'b0, busy_s[0]}, 32'h1);
    en_s[1] = 1'b1; addr_s[1] = 4'd4;
    @(negedge clk);
    idle_all();
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_dout inst=0", dout_s[0], 32'h0);
    check("rst_mid_valid inst=0", {31'b0, vld_s[0]}, 32'h0);
    check("rst_mid_busy inst=0", {31'b0, busy_s[0]}, 32'h0);
    check("rst_mid_state inst=0", {31'b0, st_s[0]}, 32'h0);
    check("rst_mid_valid inst=1", {31'b0, vld_s[1]}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++)  rd(0, 4'(k), 32'h0, 1'b0);
    for (int k = 5; k < 16; k++) rd(0, 4'(k), 32'hFFFFFFFF, 1'b0);
    idle(6);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_memory.md
# param_memory

Parametrised single-port synchronous memory, the successor to the fixed 16x32 array. It adds configurable width and depth, byte-enabled writes, a configurable read pipeline latency, a bulk-clear sequencer and out-of-range detection. It sits behind the same EN/address/Data_in/Data_out/Valid_out request interface and is driven by the class-based environment through the shared interface.

## Interface
- DATA_W, 32: data width in bits; must be a multiple of 8.
- DEPTH, 16: number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH): address width.
- RD_LAT, 1: read latency in cycles; legal values are 1 to 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset); deassertion is synchronous to clk.
- EN  in  1  request strobe; sampled on every rising edge.
- WE  in  1  request type: 1 = write, 0 = read.
- address  in  ADDR_W  word address.
- Data_in  in  DATA_W  write data.
- BE  in  DATA_W/8  byte enables for writes; bit i covers Data_in[8i+7:8i].
- CLR  in  1  bulk-clear request.
- Data_out  out  DATA_W  read data.
- Valid_out  out  1  one-cycle pulse that qualifies Data_out.
- Err  out  1  one-cycle pulse, aligned with Valid_out, on an out-of-range read.
- Busy  out  1  clear sequence in progress.

## Operation
- **Reset (rst=0).**
  - Data_out, Valid_out, Err and Busy go to 0 immediately.
  - The read pipeline is flushed and the FSM goes to IDLE.
  - Array contents are not reset.
- **FSM states.** IDLE and CLEAR.
- **IDLE.**
  - If CLR=1 at an edge, go to CLEAR. CLR has priority: an EN in the same cycle is dropped.
  - Otherwise, if EN=1, the request is accepted.
- **Write accept.**
  - For each i, mem[address] byte i takes Data_in byte i where BE[i]=1.
  - Bytes with BE=0 are unchanged.
  - No Valid_out pulse is produced.
  - If address >= DEPTH, the write is ignored silently.
- **Read accept.**
  - The word mem[address] enters a pipeline of depth RD_LAT.
  - If address >= DEPTH, Data_out=0 and Err=1 with the Valid_out pulse.
- **CLEAR.**
  - An internal counter writes all-zero words to addresses 0..DEPTH-1, one per cycle.
  - After the last address the FSM returns to IDLE.
  - EN and CLR are ignored while Busy=1.
  - Reads already in the pipeline still complete normally.
- **Throughput.** One request per cycle. Back-to-back reads and writes in any mix are allowed.
- **Data_out** holds its last value when Valid_out=0.

## Timing
- **Read.**
  - Request accepted at edge N.
  - Valid_out=1 and Data_out valid in the single cycle after edge N+RD_LAT-1.
  - For example, with RD_LAT=1 the data is visible right after edge N.
- **Write then read, same address.**
  - Write accepted at edge N, read accepted at edge N+1.
  - The read returns the newly written data; there is no stale-read hazard.
- **Clear.**
  - CLR sampled at edge N.
  - Busy=1 from after edge N until after edge N+DEPTH, i.e. for exactly DEPTH cycles.
  - The zero write to address k lands at edge N+1+k.
  - The first accepted request is at edge N+DEPTH+1 or later.
- **Read during the clear transition.** A read accepted at edge N-1 still produces its Valid_out per the rule above. It returns pre-clear data.
- **Reset mid-clear.** The clear is aborted: Busy=0 and the FSM is IDLE. Addresses not yet cleared keep their old contents.
- **Reset mid-read.** Pending Valid_out pulses are discarded.
- **Err timing.** Err is never asserted without Valid_out.

## Test plan
- **Reset and clear.** Reset, then pulse CLR -> Busy high for exactly 16 cycles; a subsequent read of addresses 0..15 returns 0x00000000 with one Valid_out per read.
- **Full write/readback.** Write address k with 0xA5A50000+k for all 16 addresses back-to-back, then read them back-to-back -> correct data returned with RD_LAT=1, and also with RD_LAT=3 (Valid_out lags the request by 3 cycles).
- **Byte enables.**
  - Write 0x11223344 to address 5 with BE=1111.
  - Then write 0xFFFFFFFF with BE=0101.
  - Read address 5 -> 0x11FF33FF.
- **Out of range.** With DEPTH=12:
  - Write 0xDEADBEEF to address 13.
  - Read address 13 -> Data_out=0, Valid_out=1, Err=1, then both drop.
  - Read address 11 -> Err=0.
- **Clear contention.**
  - CLR and an EN read asserted in the same cycle -> the read is dropped (no Valid_out).
  - EN writes during Busy are ignored: the target address reads 0 after the clear.
- **Reset mid-clear.**
  - Fill the array with 0xFFFFFFFF.
  - Pulse CLR, then assert rst=0 after 5 Busy cycles.
  - Outputs go to 0 immediately; addresses 0..4 read 0 and 5..15 read 0xFFFFFFFF.
